ula_operand_stage: RTL and testbench
====================================

# ula_operand_stage

Sequential front-end of the ULA datapath. Collects two operands and an opcode over a single valid/ready input channel, then computes the four candidate results in one execute cycle:
- sum, difference, AND, OR.
- Results are held in registers that drive the four data inputs and the 2-bit select of the downstream 4:1 result multiplexer.
- A valid/ready output handshake keeps the results stable until the consumer accepts them.

## Interface
- WIDTH, 4, operand and result width in bits.

- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  WIDTH  operand beat. First beat is A, second beat is B.
- in_op  input  2  opcode, sampled only on the B beat. 00 add, 01 sub, 10 and, 11 or.
- in_valid  input  1  in_data and in_op are valid.
- in_ready  output  1  block accepts a beat.
- res_add  output  WIDTH  registered A+B mod 2^WIDTH. Drives mux input 00.
- res_sub  output  WIDTH  registered A-B mod 2^WIDTH. Drives mux input 01.
- res_and  output  WIDTH  registered A&B. Drives mux input 10.
- res_or  output  WIDTH  registered A|B. Drives mux input 11.
- sel  output  2  registered opcode, the mux select.
- carry  output  1  carry-out of A+B.
- borrow  output  1  1 when A<B (unsigned).
- zero  output  1  1 when the result chosen by sel is all zeros.
- out_valid  output  1  results and flags are valid.
- out_ready  input  1  consumer accepts the results.

## Operation
- State machine with four states: S_A, S_B, S_EXEC, S_HOLD.
- S_A: in_ready=1. A beat (in_valid & in_ready) at a clock edge stores A and moves to S_B. With no beat the state stays in S_A.
- S_B: in_ready=1. A beat stores B and in_op and moves to S_EXEC. With no beat the state waits indefinitely; A is retained.
- S_EXEC: in_ready=0. At the edge it computes all four results, carry, borrow and zero, loads them with sel, and moves to S_HOLD.
- S_HOLD: in_ready=0 and out_valid=1.
  - out_valid & out_ready at an edge moves back to S_A.
  - Otherwise the state stays in S_HOLD with every output stable.
- in_valid is ignored whenever in_ready=0. No beat is consumed.
- Result registers keep their values after the handshake and change only in S_EXEC.
- Arithmetic is unsigned and WIDTH+1 bits wide internally:
  - carry = bit WIDTH of A+B.
  - borrow = (A<B).
  - res_sub wraps modulo 2^WIDTH.
- zero is computed from the new result selected by the new opcode and is registered with the results.
- in_ready and out_valid are decoded from state only, with no combinational path from the inputs.

## Timing
- Reset (rst_n low, asynchronous): state S_A; res_* = 0, sel = 00, carry = borrow = zero = 0, out_valid = 0, in_ready = 1.
- Reset mid-operation aborts the operation. Any partially loaded A/B is discarded.
- Latency: B accepted at edge t gives out_valid=1 from edge t+1.
- Minimum spacing: 4 cycles per operation when in_valid and out_ready are held high. The four edges are A accept, B accept, execute, and the output handshake.
- out_ready may be high before out_valid. The handshake completes on the first edge at which both are high.
- in_ready first returns to 1 in the cycle after the output handshake. A new A beat cannot be accepted on the same edge as the output handshake.

## Test plan
- Reset: drive rst_n low during S_HOLD with out_valid=1. Required response: all outputs go to the reset values without a clock edge, with in_ready=1 and out_valid=0.
- Add with carry: A=9, B=8, op=00. Required response, one cycle after B: res_add=1, carry=1, res_sub=1, borrow=0, res_and=8, res_or=9, sel=00, zero=0.
- Subtract with borrow: A=3, B=5, op=01. Required response: res_sub=E, borrow=1, res_add=8, carry=0, sel=01, zero=0.
- Zero flag and input gaps: A=F, then in_valid low for 3 cycles, then B=0 with op=10. Required response: A is retained, res_and=0, zero=1, res_or=F.
- Backpressure: out_ready low for 5 cycles in S_HOLD while in_valid toggles. Required response: all outputs stable, in_ready=0, and no beats consumed. Then raise out_ready: out_valid drops after one edge and in_ready returns to 1.
- Back-to-back: in_valid and out_ready held high and 3 operations streamed. Required response: out_valid pulses for one cycle every 4 cycles, and each result matches its own operand pair.

Source files
------------

// File: rtl/ula_operand_stage.sv
// ULA operand front-end: collects A, then B with opcode, over one valid/ready
// channel, computes add/sub/and/or in one execute cycle and holds them for the result mux.
module ula_operand_stage #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_op,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] res_add,
    output logic [WIDTH-1:0] res_sub,
    output logic [WIDTH-1:0] res_and,
    output logic [WIDTH-1:0] res_or,
    output logic [1:0]       sel,
    output logic             carry,
    output logic             borrow,
    output logic             zero,
    output logic             out_valid,
    input  logic             out_ready
);

    typedef enum logic [1:0] {
        S_A    = 2'd0,
        S_B    = 2'd1,
        S_EXEC = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] res_add_q, res_add_d;
    logic [WIDTH-1:0] res_sub_q, res_sub_d;
    logic [WIDTH-1:0] res_and_q, res_and_d;
    logic [WIDTH-1:0] res_or_q, res_or_d;
    logic [1:0]       sel_q, sel_d;
    logic             carry_q, carry_d;
    logic             borrow_q, borrow_d;
    logic             zero_q, zero_d;

    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;
    logic [WIDTH-1:0] and_v;
    logic [WIDTH-1:0] or_v;
    logic [WIDTH-1:0] chosen;

    // Handshake outputs come from state alone, so no input reaches them combinationally.
    assign in_ready  = (state_q == S_A) || (state_q == S_B);
    assign out_valid = (state_q == S_HOLD);

    // The top bit of the widened difference is set exactly when A < B.
    assign sum_ext  = {1'b0, a_q} + {1'b0, b_q};
    assign diff_ext = {1'b0, a_q} - {1'b0, b_q};
    assign and_v    = a_q & b_q;
    assign or_v     = a_q | b_q;

    always_comb begin
        // NOTE: every always_comb target gets a default first so no path leaves it unassigned (no latch).
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        res_add_d = res_add_q;
        res_sub_d = res_sub_q;
        res_and_d = res_and_q;
        res_or_d  = res_or_q;
        sel_d     = sel_q;
        carry_d   = carry_q;
        borrow_d  = borrow_q;
        zero_d    = zero_q;

        unique case (op_q)
            2'b00:   chosen = sum_ext[WIDTH-1:0];
            2'b01:   chosen = diff_ext[WIDTH-1:0];
            2'b10:   chosen = and_v;
            default: chosen = or_v;
        endcase

        unique case (state_q)
            S_A: begin
                if (in_valid) begin
                    a_d     = in_data;
                    state_d = S_B;
                end
            end
            S_B: begin
                if (in_valid) begin
                    b_d     = in_data;
                    op_d    = in_op;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                res_add_d = sum_ext[WIDTH-1:0];
                res_sub_d = diff_ext[WIDTH-1:0];
                res_and_d = and_v;
                res_or_d  = or_v;
                carry_d   = sum_ext[WIDTH];
                borrow_d  = diff_ext[WIDTH];
                sel_d     = op_q;
                zero_d    = (chosen == '0);
                state_d   = S_HOLD;
            end
            default: begin
                if (out_ready) begin
                    state_d = S_A;
                end
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_A;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= 2'b00;
            res_add_q <= '0;
            res_sub_q <= '0;
            res_and_q <= '0;
            res_or_q  <= '0;
            sel_q     <= 2'b00;
            carry_q   <= 1'b0;
            borrow_q  <= 1'b0;
            zero_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            res_add_q <= res_add_d;
            res_sub_q <= res_sub_d;
            res_and_q <= res_and_d;
            res_or_q  <= res_or_d;
            sel_q     <= sel_d;
            carry_q   <= carry_d;
            borrow_q  <= borrow_d;
            zero_q    <= zero_d;
        end
    end

    assign res_add = res_add_q;
    assign res_sub = res_sub_q;
    assign res_and = res_and_q;
    assign res_or  = res_or_q;
    assign sel     = sel_q;
    assign carry   = carry_q;
    assign borrow  = borrow_q;
    assign zero    = zero_q;

endmodule

// File: tb/tb_ula_operand_stage.sv
// Directed bench for ula_operand_stage: hand-computed vectors, immediate-assertion checks,
// inputs driven and outputs sampled 1 time unit after each rising edge.
module tb_ula_operand_stage;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_op;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] res_add, res_sub, res_and, res_or;
    logic [1:0]       sel;
    logic             carry, borrow, zero;
    logic             out_valid;
    logic             out_ready;

    int n_cmp = 0;
    int n_err = 0;

    ula_operand_stage #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_op     (in_op),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .res_add   (res_add),
        .res_sub   (res_sub),
        .res_and   (res_and),
        .res_or    (res_or),
        .sel       (sel),
        .carry     (carry),
        .borrow    (borrow),
        .zero      (zero),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected full output set: add, sub, and, or, sel, carry, borrow, zero.
    task automatic check_res(input string tag,
                             input logic [3:0] e_add, input logic [3:0] e_sub,
                             input logic [3:0] e_and, input logic [3:0] e_or,
                             input logic [1:0] e_sel, input logic e_c,
                             input logic e_b, input logic e_z);
        check({tag, ".add"},    {4'h0, res_add}, {4'h0, e_add});
        check({tag, ".sub"},    {4'h0, res_sub}, {4'h0, e_sub});
        check({tag, ".and"},    {4'h0, res_and}, {4'h0, e_and});
        check({tag, ".or"},     {4'h0, res_or},  {4'h0, e_or});
        check({tag, ".sel"},    {6'h0, sel},     {6'h0, e_sel});
        check({tag, ".carry"},  {7'h0, carry},   {7'h0, e_c});
        check({tag, ".borrow"}, {7'h0, borrow},  {7'h0, e_b});
        check({tag, ".zero"},   {7'h0, zero},    {7'h0, e_z});
    endtask

    task automatic send(input logic [3:0] data, input logic [1:0] op);
        in_data  = data;
        in_op    = op;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    logic [3:0] bb_a   [3] = '{4'h7, 4'hC, 4'h5};
    logic [3:0] bb_b   [3] = '{4'h9, 4'h4, 4'hA};
    logic [1:0] bb_op  [3] = '{2'b00, 2'b01, 2'b11};
    logic [3:0] bb_add [3] = '{4'h0, 4'h0, 4'hF};
    logic [3:0] bb_sub [3] = '{4'hE, 4'h8, 4'hB};
    logic [3:0] bb_and [3] = '{4'h1, 4'h4, 4'h0};
    logic [3:0] bb_or  [3] = '{4'hF, 4'hC, 4'hF};
    logic       bb_c   [3] = '{1'b1, 1'b1, 1'b0};
    logic       bb_b2  [3] = '{1'b1, 1'b0, 1'b1};
    logic       bb_z   [3] = '{1'b1, 1'b0, 1'b0};

    initial begin
        rst_n     = 1'b0;
        in_data   = '0;
        in_op     = 2'b00;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Reset state
        check("rst.in_ready",  {7'h0, in_ready},  8'h1);
        check("rst.out_valid", {7'h0, out_valid}, 8'h0);
        check_res("rst", 4'h0, 4'h0, 4'h0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0);

        // Add with carry: 9 + 8
        send(4'h9, 2'b00);
        check("add.in_ready_b", {7'h0, in_ready}, 8'h1);
        send(4'h8, 2'b00);
        check("add.exec_in_ready",  {7'h0, in_ready},  8'h0);
        check("add.exec_out_valid", {7'h0, out_valid}, 8'h0);
        tick();
        check("add.out_valid", {7'h0, out_valid}, 8'h1);
        check_res("add", 4'h1, 4'h1, 4'h8, 4'h9, 2'b00, 1'b1, 1'b0, 1'b0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("add.hs_out_valid", {7'h0, out_valid}, 8'h0);
        check("add.hs_in_ready",  {7'h0, in_ready},  8'h1);
        check("add.retained", {4'h0, res_add}, 8'h1);

        // Subtract with borrow: 3 - 5
        send(4'h3, 2'b00);
        send(4'h5, 2'b01);
        tick();
        check("sub.out_valid", {7'h0, out_valid}, 8'h1);
        check_res("sub", 4'h8, 4'hE, 4'h1, 4'h7, 2'b01, 1'b0, 1'b1, 1'b0);

        // Backpressure: out_ready low, in_valid toggling with data that would change results
        in_data = 4'hF;
        in_op   = 2'b10;
        for (int i = 0; i < 5; i++) begin
            in_valid = ~in_valid;
            tick();
            check("bp.in_ready",  {7'h0, in_ready},  8'h0);
            check("bp.out_valid", {7'h0, out_valid}, 8'h1);
            check_res("bp", 4'h8, 4'hE, 4'h1, 4'h7, 2'b01, 1'b0, 1'b1, 1'b0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp.release_out_valid", {7'h0, out_valid}, 8'h0);
        check("bp.release_in_ready",  {7'h0, in_ready},  8'h1);

        // Zero flag with input gaps: A=F, 3 idle cycles, B=0 op=and
        send(4'hF, 2'b00);
        in_data = 4'h3;
        repeat (3) begin
            tick();
            check("gap.in_ready",  {7'h0, in_ready},  8'h1);
            check("gap.out_valid", {7'h0, out_valid}, 8'h0);
        end
        send(4'h0, 2'b10);
        tick();
        check("zero.out_valid", {7'h0, out_valid}, 8'h1);
        check_res("zero", 4'hF, 4'hF, 4'h0, 4'hF, 2'b10, 1'b0, 1'b0, 1'b1);
        out_ready = 1'b1;
        tick();

        // Back-to-back: in_valid and out_ready held high, 4 cycles per operation
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_data = bb_a[k];
            in_op   = 2'b00;
            check("b2b.pA_out_valid", {7'h0, out_valid}, 8'h0);
            check("b2b.pA_in_ready",  {7'h0, in_ready},  8'h1);
            tick();
            in_data = bb_b[k];
            in_op   = bb_op[k];
            check("b2b.pB_out_valid", {7'h0, out_valid}, 8'h0);
            check("b2b.pB_in_ready",  {7'h0, in_ready},  8'h1);
            tick();
            in_data = 4'h6;
            in_op   = 2'b10;
            check("b2b.pE_out_valid", {7'h0, out_valid}, 8'h0);
            check("b2b.pE_in_ready",  {7'h0, in_ready},  8'h0);
            tick();
            check("b2b.pH_out_valid", {7'h0, out_valid}, 8'h1);
            check("b2b.pH_in_ready",  {7'h0, in_ready},  8'h0);
            check_res($sformatf("b2b%0d", k), bb_add[k], bb_sub[k], bb_and[k], bb_or[k],
                      bb_op[k], bb_c[k], bb_b2[k], bb_z[k]);
            tick();
        end
        check("b2b.end_out_valid", {7'h0, out_valid}, 8'h0);
        in_valid  = 1'b0;
        out_ready = 1'b0;

        // Asynchronous reset while holding results
        tick();
        send(4'h9, 2'b00);
        send(4'h8, 2'b00);
        tick();
        check("arst.pre_out_valid", {7'h0, out_valid}, 8'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.in_ready",  {7'h0, in_ready},  8'h1);
        check("arst.out_valid", {7'h0, out_valid}, 8'h0);
        check_res("arst", 4'h0, 4'h0, 4'h0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;

        // Reset after a partial load discards A: new pair 6,1 must give 7
        send(4'h2, 2'b00);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
        check("abort.in_ready", {7'h0, in_ready}, 8'h1);
        send(4'h6, 2'b00);
        send(4'h1, 2'b00);
        tick();
        check("abort.out_valid", {7'h0, out_valid}, 8'h1);
        check_res("abort", 4'h7, 4'h5, 4'h0, 4'h7, 2'b00, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
